// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive-FSM state type and the reflected CRC-32 byte step.
// The CRC step is a plain function so TX-side models can reuse it.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PRE_BAD,
        S_END
    } eth_rx_state_e;

    // One byte absorbed LSB-first; no final inversion, so a frame including its FCS leaves the residue.
    function automatic logic [31:0] crc32_byte_refl(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_rx_fcs_check.sv
// Passive GMII receive monitor: preamble/SFD detection, CRC-32 residue check,
// per-frame verdict strobe and good/bad frame counters.
module gmii_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             rst_n,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    input  logic             cnt_clr,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_ok,
    output logic             short_err,
    output logic             long_err,
    output logic             pre_err,
    output logic [15:0]      frame_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
    localparam logic [3:0]  PRE_MAX = 4'd7;

    eth_rx_state_e    state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             crc_ok_q, crc_ok_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             pre_err_q, pre_err_d;
    logic [15:0]      len_q, len_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             pre_fail;
    logic             data_crc_ok;
    logic             data_short;
    logic             data_long;

    assign data_crc_ok = (crc_q == CRC32_RESIDUE);
    assign data_short  = (byte_cnt_q < MIN_LEN);
    assign data_long   = (byte_cnt_q > MAX_LEN);

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        crc_d      = crc_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        crc_ok_d   = crc_ok_q;
        short_d    = short_q;
        long_d     = long_q;
        pre_err_d  = pre_err_q;
        len_d      = len_q;
        pre_fail   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == ETH_PREAMBLE) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = S_PRE_BAD;
                    end
                end
            end
            S_PRE: begin
                if (!gmii_rx_dv) begin
                    pre_fail = 1'b1;
                end else if (gmii_rxd == ETH_PREAMBLE) begin
                    // An eighth preamble byte means the SFD can no longer arrive in time.
                    if (pre_cnt_q == PRE_MAX) state_d = S_PRE_BAD;
                    else                      pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (gmii_rxd == ETH_SFD) begin
                    state_d    = S_DATA;
                    crc_d      = CRC32_INIT;
                    byte_cnt_d = '0;
                end else begin
                    state_d = S_PRE_BAD;
                end
            end
            S_DATA: begin
                if (gmii_rx_dv) begin
                    crc_d = crc32_byte_refl(crc_q, gmii_rxd);
                    if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
                end else begin
                    state_d   = S_END;
                    done_d    = 1'b1;
                    crc_ok_d  = data_crc_ok;
                    short_d   = data_short;
                    long_d    = data_long;
                    pre_err_d = 1'b0;
                    ok_d      = data_crc_ok && !data_short && !data_long;
                    len_d     = (byte_cnt_q >= 16'd4) ? (byte_cnt_q - 16'd4) : 16'd0;
                end
            end
            S_PRE_BAD: begin
                if (!gmii_rx_dv) pre_fail = 1'b1;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pre_fail) begin
            state_d   = S_END;
            done_d    = 1'b1;
            ok_d      = 1'b0;
            crc_ok_d  = 1'b0;
            short_d   = 1'b0;
            long_d    = 1'b0;
            pre_err_d = 1'b1;
            len_d     = 16'd0;
        end

        // Counters follow the registered verdict; a clear in the same cycle wins.
        good_d = good_q;
        bad_d  = bad_q;
        if (cnt_clr) begin
            good_d = '0;
            bad_d  = '0;
        end else if (done_q) begin
            if (ok_q) good_d = good_q + CNT_W'(1);
            else      bad_d  = bad_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            crc_q      <= CRC32_INIT;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            crc_ok_q   <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            pre_err_q  <= 1'b0;
            len_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            crc_ok_q   <= crc_ok_d;
            short_q    <= short_d;
            long_q     <= long_d;
            pre_err_q  <= pre_err_d;
            len_q      <= len_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign crc_ok     = crc_ok_q;
    assign short_err  = short_q;
    assign long_err   = long_q;
    assign pre_err    = pre_err_q;
    assign frame_len  = len_q;
    assign good_cnt   = good_q;
    assign bad_cnt    = bad_q;

endmodule
